// File: rtl/sm_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encodings and the
// default prescale exponent, also used by the top level and debug display.
package sm_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } run_state_e;

  localparam int SHIFT_DEFAULT = 16;

endpackage

// File: rtl/sm_tick_gen.sv
// Prescaler for the run controller. Counts while enabled and flags a tick
// once the count reaches 2^(SHIFT+devide)-1. The >= compare means lowering
// devide mid-count ticks immediately instead of wrapping round.
module sm_tick_gen
  import sm_run_ctrl_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [3:0] devide_i,
  output logic       tick_o
);

  localparam int CW = SHIFT + 16;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] limit;

  // Terminal count for the selected rate and the resulting tick.
  always_comb begin
    limit  = (CW'(1) << (SHIFT + int'(devide_i))) - CW'(1);
    tick_o = en_i && (cnt_q >= limit);
  end

  // Restart on command, hold at zero when idle, wrap to zero on tick.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || !en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_run_ctrl.sv
// CPU execution controller: issues one-cycle cpuEn pulses at a programmable
// rate in free-run or N-step burst mode, with an optional PC breakpoint.
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int SHIFT  = SHIFT_DEFAULT,
  parameter int STEP_W = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmdRun,
  input  logic              cmdHalt,
  input  logic              cmdStep,
  input  logic [STEP_W-1:0] stepCount,
  input  logic [3:0]        devide,
  input  logic              bpEnable,
  input  logic [ADDR_W-1:0] bpAddr,
  input  logic [ADDR_W-1:0] imAddr,
  output logic              cpuEn,
  output logic [1:0]        state,
  output logic              bpHit,
  output logic [31:0]       stepsDone
);

  run_state_e        state_q, state_d;
  logic              cpuEn_q, cpuEn_d;
  logic              bpHit_q, bpHit_d;
  logic              skipBp_q, skipBp_d;
  logic [31:0]       steps_q, steps_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              accept;
  logic              pulse;
  logic              bpMatch;
  logic              tick;

  sm_tick_gen #(
    .SHIFT (SHIFT)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (accept),
    .en_i     (state_q != ST_HALT),
    .devide_i (devide),
    .tick_o   (tick)
  );

  // Mode transitions, breakpoint check and pulse generation for this cycle.
  always_comb begin
    state_d     = state_q;
    cpuEn_d     = 1'b0;
    bpHit_d     = bpHit_q;
    skipBp_d    = skipBp_q;
    steps_d     = steps_q;
    remaining_d = remaining_q;
    accept      = 1'b0;
    pulse       = 1'b0;
    bpMatch     = bpEnable && (imAddr == bpAddr) && !skipBp_q;

    case (state_q)
      ST_HALT: begin
        if (cmdHalt) begin
          state_d = ST_HALT;
        end else if (cmdRun) begin
          state_d = ST_RUN;
          accept  = 1'b1;
        end else if (cmdStep) begin
          state_d     = ST_BURST;
          remaining_d = (stepCount == '0) ? STEP_W'(1) : stepCount;
          accept      = 1'b1;
        end
      end
      ST_RUN: begin
        if (cmdHalt) begin
          state_d = ST_HALT;
          accept  = 1'b1;
        end else if (tick) begin
          skipBp_d = 1'b0;
          if (bpMatch) begin
            state_d = ST_HALT;
            bpHit_d = 1'b1;
          end else begin
            pulse = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (cmdHalt || cmdRun) begin
          state_d     = cmdHalt ? ST_HALT : ST_RUN;
          remaining_d = '0;
          accept      = 1'b1;
        end else if (tick) begin
          skipBp_d = 1'b0;
          if (bpMatch) begin
            state_d     = ST_HALT;
            bpHit_d     = 1'b1;
            remaining_d = '0;
          end else begin
            pulse       = 1'b1;
            remaining_d = remaining_q - STEP_W'(1);
            if (remaining_q == STEP_W'(1)) begin
              state_d = ST_HALT;
            end
          end
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (accept) begin
      skipBp_d = 1'b1;
      bpHit_d  = 1'b0;
    end
    if (pulse) begin
      cpuEn_d = 1'b1;
      steps_d = steps_q + 32'd1;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      cpuEn_q     <= 1'b0;
      bpHit_q     <= 1'b0;
      skipBp_q    <= 1'b1;
      steps_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cpuEn_q     <= cpuEn_d;
      bpHit_q     <= bpHit_d;
      skipBp_q    <= skipBp_d;
      steps_q     <= steps_d;
      remaining_q <= remaining_d;
    end
  end

  assign cpuEn     = cpuEn_q;
  assign state     = state_q;
  assign bpHit     = bpHit_q;
  assign stepsDone = steps_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Testbench for sm_run_ctrl: scripted scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_sm_run_ctrl;

  localparam int SHIFT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmdRun, cmdHalt, cmdStep;
  logic [7:0]  stepCount;
  logic [3:0]  devide;
  logic        bpEnable;
  logic [31:0] bpAddr, imAddr;
  logic        cpuEn;
  logic [1:0]  state;
  logic        bpHit;
  logic [31:0] stepsDone;

  int checks = 0;
  int fails = 0;
  int dutPulses = 0;
  bit trackPc = 1'b0;
  logic [31:0] pcMask = 32'hFFFF_FFFF;

  // Behavioural model: mode 0/1/2, edges waited since last restart or tick,
  // steps left in a burst, and whether the breakpoint is armed.
  int          mState;
  bit          mCpuEn, mBpHit, mArmed;
  logic [31:0] mSteps;
  int          mWait, mLeft;

  // Free-running system clock.
  always #5 clk = ~clk;

  sm_run_ctrl #(
    .SHIFT  (SHIFT),
    .STEP_W (8),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmdRun    (cmdRun),
    .cmdHalt   (cmdHalt),
    .cmdStep   (cmdStep),
    .stepCount (stepCount),
    .devide    (devide),
    .bpEnable  (bpEnable),
    .bpAddr    (bpAddr),
    .imAddr    (imAddr),
    .cpuEn     (cpuEn),
    .state     (state),
    .bpHit     (bpHit),
    .stepsDone (stepsDone)
  );

  task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelStep();
    int  period;
    bit  fired, restart, pulse, hit;
    int  next;
    if (!rst_n) begin
      mState = 0; mCpuEn = 0; mBpHit = 0; mSteps = '0;
      mWait = 0; mLeft = 0; mArmed = 0;
      return;
    end
    period  = 1 << (SHIFT + int'(devide));
    fired   = (mState != 0) && (mWait + 1 >= period);
    next    = mState;
    restart = 0;
    pulse   = 0;
    if (cmdHalt) begin
      if (mState != 0) begin next = 0; mLeft = 0; restart = 1; end
    end else if (cmdRun && mState != 1) begin
      next = 1; mLeft = 0; restart = 1;
    end else if (cmdStep && mState == 0) begin
      next = 2; mLeft = (stepCount == 0) ? 1 : int'(stepCount); restart = 1;
    end else if (fired) begin
      hit    = bpEnable && (imAddr == bpAddr) && mArmed;
      mArmed = 1;
      if (hit) begin
        next = 0; mBpHit = 1; mLeft = 0;
      end else begin
        pulse = 1;
        if (mState == 2) begin
          mLeft--;
          if (mLeft == 0) next = 0;
        end
      end
    end
    if (restart) begin
      mArmed = 0;
      mBpHit = 0;
    end
    if (restart || fired || mState == 0) mWait = 0;
    else mWait++;
    mCpuEn = pulse;
    if (pulse) mSteps = mSteps + 32'd1;
    mState = next;
  endtask

  task automatic checkOutput();
    checkLit("cpuEn", 32'(cpuEn), 32'(mCpuEn));
    checkLit("state", 32'(state), 32'(mState));
    checkLit("bpHit", 32'(bpHit), 32'(mBpHit));
    checkLit("stepsDone", stepsDone, mSteps);
  endtask

  // Run n clock edges; commands are one-shot and drop after the first edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      modelStep();
      checkOutput();
      dutPulses += int'(cpuEn);
      if (trackPc && mCpuEn) imAddr = (imAddr + 32'd4) & pcMask;
      if (trackPc && !rst_n) imAddr = '0;
      cmdRun  = 1'b0;
      cmdHalt = 1'b0;
      cmdStep = 1'b0;
    end
  endtask

  // Scenario sequence followed by randomized traffic.
  initial begin
    rst_n = 1'b0; cmdRun = 1'b0; cmdHalt = 1'b0; cmdStep = 1'b0;
    stepCount = 8'd0; devide = 4'd0; bpEnable = 1'b0;
    bpAddr = '0; imAddr = '0;

    $display("[TB] reset and idle");
    applyStimulus(3);
    rst_n = 1'b1;
    dutPulses = 0;
    applyStimulus(50);
    checkLit("idle_state", 32'(state), 32'd0);
    checkLit("idle_pulses", 32'(dutPulses), 32'd0);
    checkLit("idle_steps", stepsDone, 32'd0);

    $display("[TB] free-run at T=8");
    devide = 4'd1; cmdRun = 1'b1;
    applyStimulus(1);
    applyStimulus(7);
    checkLit("run_e7", 32'(cpuEn), 32'd0);
    applyStimulus(1);
    checkLit("run_e8", 32'(cpuEn), 32'd1);
    applyStimulus(8);
    checkLit("run_e16", 32'(cpuEn), 32'd1);
    applyStimulus(8);
    checkLit("run_e24", 32'(cpuEn), 32'd1);
    applyStimulus(5);
    cmdHalt = 1'b1;
    applyStimulus(1);
    dutPulses = 0;
    applyStimulus(20);
    checkLit("run_after_halt_pulses", 32'(dutPulses), 32'd0);
    checkLit("run_halt_state", 32'(state), 32'd0);
    checkLit("run_steps", stepsDone, 32'd3);

    $display("[TB] burst of 3 then burst of 0");
    devide = 4'd0; stepCount = 8'd3; cmdStep = 1'b1; dutPulses = 0;
    applyStimulus(1);
    applyStimulus(3);
    checkLit("burst_e3", 32'(cpuEn), 32'd0);
    applyStimulus(1);
    checkLit("burst_e4", 32'(cpuEn), 32'd1);
    applyStimulus(4);
    checkLit("burst_e8", 32'(cpuEn), 32'd1);
    applyStimulus(4);
    checkLit("burst_e12", 32'(cpuEn), 32'd1);
    checkLit("burst_e12_state", 32'(state), 32'd0);
    applyStimulus(20);
    checkLit("burst3_pulses", 32'(dutPulses), 32'd3);
    stepCount = 8'd0; cmdStep = 1'b1; dutPulses = 0;
    applyStimulus(1);
    applyStimulus(4);
    checkLit("burst0_e4", 32'(cpuEn), 32'd1);
    checkLit("burst0_state", 32'(state), 32'd0);
    applyStimulus(20);
    checkLit("burst0_pulses", 32'(dutPulses), 32'd1);

    $display("[TB] breakpoint");
    imAddr = '0; trackPc = 1'b1; bpEnable = 1'b1; bpAddr = 32'h10;
    cmdRun = 1'b1; dutPulses = 0;
    applyStimulus(1);
    applyStimulus(40);
    checkLit("bp_pulses", 32'(dutPulses), 32'd4);
    checkLit("bp_state", 32'(state), 32'd0);
    checkLit("bp_hit", 32'(bpHit), 32'd1);
    cmdRun = 1'b1;
    applyStimulus(1);
    checkLit("bp_hit_cleared", 32'(bpHit), 32'd0);
    applyStimulus(3);
    checkLit("bp_resume_e3", 32'(cpuEn), 32'd0);
    applyStimulus(1);
    checkLit("bp_resume_e4", 32'(cpuEn), 32'd1);
    cmdHalt = 1'b1;
    applyStimulus(1);
    trackPc = 1'b0; bpEnable = 1'b0;

    $display("[TB] command priority and rate change");
    cmdRun = 1'b1;
    applyStimulus(2);
    cmdHalt = 1'b1; cmdRun = 1'b1;
    applyStimulus(1);
    checkLit("prio_state", 32'(state), 32'd0);
    devide = 4'd3; cmdRun = 1'b1;
    applyStimulus(1);
    applyStimulus(20);
    checkLit("rate_e20", 32'(cpuEn), 32'd0);
    devide = 4'd0;
    applyStimulus(1);
    checkLit("rate_e21", 32'(cpuEn), 32'd1);
    applyStimulus(3);
    checkLit("rate_e24", 32'(cpuEn), 32'd0);
    applyStimulus(1);
    checkLit("rate_e25", 32'(cpuEn), 32'd1);
    cmdHalt = 1'b1;
    applyStimulus(1);

    $display("[TB] reset mid-burst");
    stepCount = 8'd5; cmdStep = 1'b1;
    applyStimulus(1);
    applyStimulus(9);
    rst_n = 1'b0;
    applyStimulus(1);
    checkLit("rst_state", 32'(state), 32'd0);
    checkLit("rst_steps", stepsDone, 32'd0);
    checkLit("rst_cpuEn", 32'(cpuEn), 32'd0);
    rst_n = 1'b1; dutPulses = 0;
    applyStimulus(30);
    checkLit("rst_after_pulses", 32'(dutPulses), 32'd0);

    $display("[TB] randomized traffic");
    imAddr = '0; trackPc = 1'b1; pcMask = 32'h1F;
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      cmdRun    = ($urandom_range(0, 39) == 0);
      cmdHalt   = ($urandom_range(0, 59) == 0);
      cmdStep   = ($urandom_range(0, 29) == 0);
      stepCount = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) devide = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) bpEnable = ~bpEnable;
      if ($urandom_range(0, 99) == 0) bpAddr = 32'(4 * $urandom_range(0, 7));
      applyStimulus(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
